// File: rtl/variable_latency_rob_pkg.sv
// Shared sizing helpers for the variable-latency reorder adapter.
package variable_latency_rob_pkg;

  // Transaction tag width: at least one bit even for a single-entry buffer.
  function automatic int id_width(input int max_outstanding);
    return (max_outstanding == 1) ? 1 : $clog2(max_outstanding);
  endfunction

  // Occupancy counter width: must represent 0..max_outstanding inclusive.
  function automatic int count_width(input int max_outstanding);
    return id_width(max_outstanding) + 1;
  endfunction

endpackage

// File: rtl/variable_latency_rob_slice.sv
// One reorder channel: tags requests, captures out-of-order responses,
// and hands them back to the core in issue order.
module variable_latency_rob_slice
  import variable_latency_rob_pkg::*;
#(
  parameter int AddrWidth      = 32,
  parameter int DataWidth      = 32,
  parameter int BeWidth        = DataWidth / 8,
  parameter int MaxOutstanding = 8,
  parameter int IdWidth        = id_width(MaxOutstanding)
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 core_req_valid_i,
  output logic                 core_req_ready_o,
  input  logic [AddrWidth-1:0] core_req_addr_i,
  input  logic                 core_req_wen_i,
  input  logic [DataWidth-1:0] core_req_wdata_i,
  input  logic [BeWidth-1:0]   core_req_be_i,
  output logic                 core_resp_valid_o,
  input  logic                 core_resp_ready_i,
  output logic [DataWidth-1:0] core_resp_rdata_o,
  output logic                 net_req_valid_o,
  input  logic                 net_req_ready_i,
  output logic [IdWidth-1:0]   net_req_id_o,
  output logic [AddrWidth-1:0] net_req_addr_o,
  output logic                 net_req_wen_o,
  output logic [DataWidth-1:0] net_req_wdata_o,
  output logic [BeWidth-1:0]   net_req_be_o,
  input  logic                 net_resp_valid_i,
  output logic                 net_resp_ready_o,
  input  logic [IdWidth-1:0]   net_resp_id_i,
  input  logic [DataWidth-1:0] net_resp_rdata_i,
  output logic [IdWidth:0]     outstanding_o,
  output logic                 err_o
);

  localparam int CW = IdWidth + 1;
  localparam logic [IdWidth-1:0] PTR_LAST = IdWidth'(MaxOutstanding - 1);

  logic [IdWidth-1:0]   r_head;
  logic [IdWidth-1:0]   r_tail;
  logic [CW-1:0]        r_count;
  logic [MaxOutstanding-1:0] r_valid;
  logic [DataWidth-1:0] r_data [MaxOutstanding];
  logic                 r_err;

  logic               w_full;
  logic               w_alloc;
  logic               w_retire;
  logic               w_resp;
  logic               w_resp_err;
  logic               w_id_ok;
  logic               w_alloc_hit;
  logic [IdWidth-1:0] w_offset;

  // Pointers wrap at MaxOutstanding; also correct for the single-entry case.
  function automatic logic [IdWidth-1:0] ptr_inc(input logic [IdWidth-1:0] p);
    return (p == PTR_LAST) ? '0 : p + 1'b1;
  endfunction

  // Full uses the registered count only, so a retire never frees a slot
  // for a request in the same cycle.
  assign w_full   = (r_count == CW'(MaxOutstanding));
  assign w_alloc  = core_req_valid_i & net_req_ready_i & ~w_full & ~rst_i;
  assign w_retire = r_valid[r_head] & core_resp_ready_i & ~rst_i;
  assign w_resp   = net_resp_valid_i & ~rst_i;

  // An id is allocated when it lies in the window [head, head+count).
  assign w_id_ok     = ({1'b0, net_resp_id_i} < CW'(MaxOutstanding));
  assign w_offset    = net_resp_id_i - r_head;
  assign w_alloc_hit = w_id_ok & ({1'b0, w_offset} < r_count);
  assign w_resp_err  = w_resp & (~w_alloc_hit | r_valid[net_resp_id_i]);

  assign core_req_ready_o  = net_req_ready_i & ~w_full & ~rst_i;
  assign net_req_valid_o   = core_req_valid_i & ~w_full & ~rst_i;
  assign net_req_id_o      = r_tail;
  assign net_req_addr_o    = core_req_addr_i;
  assign net_req_wen_o     = core_req_wen_i;
  assign net_req_wdata_o   = core_req_wdata_i;
  assign net_req_be_o      = core_req_be_i;
  assign net_resp_ready_o  = ~rst_i;
  assign core_resp_valid_o = r_valid[r_head] & ~rst_i;
  assign core_resp_rdata_o = r_data[r_head];
  assign outstanding_o     = r_count;
  assign err_o             = r_err;

  // Pointer, occupancy, valid-bit and sticky error bookkeeping.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      r_valid <= '0;
      r_err   <= 1'b0;
    end else begin
      if (w_alloc)  r_tail <= ptr_inc(r_tail);
      if (w_retire) r_head <= ptr_inc(r_head);
      r_count <= r_count + CW'(w_alloc) - CW'(w_retire);
      if (w_retire) r_valid[r_head] <= 1'b0;
      if (w_resp && !w_resp_err) r_valid[net_resp_id_i] <= 1'b1;
      if (w_resp_err) r_err <= 1'b1;
    end
  end

  // Response data capture; written even on a protocol error, never reset.
  always_ff @(posedge clk_i) begin
    if (w_resp && w_id_ok) r_data[net_resp_id_i] <= net_resp_rdata_i;
  end

endmodule

// File: rtl/variable_latency_rob_adapter.sv
// Multi-channel reorder adapter: NumPorts independent reorder slices.
module variable_latency_rob_adapter
  import variable_latency_rob_pkg::*;
#(
  parameter int NumPorts       = 4,
  parameter int AddrWidth      = 32,
  parameter int DataWidth      = 32,
  parameter int BeWidth        = DataWidth / 8,
  parameter int MaxOutstanding = 8
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic [NumPorts-1:0]           core_req_valid_i,
  output logic [NumPorts-1:0]           core_req_ready_o,
  input  logic [NumPorts*AddrWidth-1:0] core_req_addr_i,
  input  logic [NumPorts-1:0]           core_req_wen_i,
  input  logic [NumPorts*DataWidth-1:0] core_req_wdata_i,
  input  logic [NumPorts*BeWidth-1:0]   core_req_be_i,
  output logic [NumPorts-1:0]           core_resp_valid_o,
  input  logic [NumPorts-1:0]           core_resp_ready_i,
  output logic [NumPorts*DataWidth-1:0] core_resp_rdata_o,
  output logic [NumPorts-1:0]           net_req_valid_o,
  input  logic [NumPorts-1:0]           net_req_ready_i,
  output logic [NumPorts*id_width(MaxOutstanding)-1:0] net_req_id_o,
  output logic [NumPorts*AddrWidth-1:0] net_req_addr_o,
  output logic [NumPorts-1:0]           net_req_wen_o,
  output logic [NumPorts*DataWidth-1:0] net_req_wdata_o,
  output logic [NumPorts*BeWidth-1:0]   net_req_be_o,
  input  logic [NumPorts-1:0]           net_resp_valid_i,
  output logic [NumPorts-1:0]           net_resp_ready_o,
  input  logic [NumPorts*id_width(MaxOutstanding)-1:0] net_resp_id_i,
  input  logic [NumPorts*DataWidth-1:0] net_resp_rdata_i,
  output logic [NumPorts*(id_width(MaxOutstanding)+1)-1:0] outstanding_o,
  output logic [NumPorts-1:0]           err_o
);

  localparam int IdWidth = id_width(MaxOutstanding);

  // Elaboration-time parameter sanity.
  if ((MaxOutstanding < 1) || ((MaxOutstanding & (MaxOutstanding - 1)) != 0)) begin : g_bad_depth
    $error("MaxOutstanding must be a power of 2 and at least 1");
  end
  if (IdWidth < 1) begin : g_bad_id
    $error("IdWidth must be at least 1");
  end

  // One fully independent reorder slice per channel.
  for (genvar g = 0; g < NumPorts; g++) begin : g_chan
    variable_latency_rob_slice #(
      .AddrWidth      (AddrWidth),
      .DataWidth      (DataWidth),
      .BeWidth        (BeWidth),
      .MaxOutstanding (MaxOutstanding),
      .IdWidth        (IdWidth)
    ) u_slice (
      .clk_i             (clk_i),
      .rst_i             (rst_i),
      .core_req_valid_i  (core_req_valid_i[g]),
      .core_req_ready_o  (core_req_ready_o[g]),
      .core_req_addr_i   (core_req_addr_i[g*AddrWidth +: AddrWidth]),
      .core_req_wen_i    (core_req_wen_i[g]),
      .core_req_wdata_i  (core_req_wdata_i[g*DataWidth +: DataWidth]),
      .core_req_be_i     (core_req_be_i[g*BeWidth +: BeWidth]),
      .core_resp_valid_o (core_resp_valid_o[g]),
      .core_resp_ready_i (core_resp_ready_i[g]),
      .core_resp_rdata_o (core_resp_rdata_o[g*DataWidth +: DataWidth]),
      .net_req_valid_o   (net_req_valid_o[g]),
      .net_req_ready_i   (net_req_ready_i[g]),
      .net_req_id_o      (net_req_id_o[g*IdWidth +: IdWidth]),
      .net_req_addr_o    (net_req_addr_o[g*AddrWidth +: AddrWidth]),
      .net_req_wen_o     (net_req_wen_o[g]),
      .net_req_wdata_o   (net_req_wdata_o[g*DataWidth +: DataWidth]),
      .net_req_be_o      (net_req_be_o[g*BeWidth +: BeWidth]),
      .net_resp_valid_i  (net_resp_valid_i[g]),
      .net_resp_ready_o  (net_resp_ready_o[g]),
      .net_resp_id_i     (net_resp_id_i[g*IdWidth +: IdWidth]),
      .net_resp_rdata_i  (net_resp_rdata_i[g*DataWidth +: DataWidth]),
      .outstanding_o     (outstanding_o[g*(IdWidth+1) +: IdWidth+1]),
      .err_o             (err_o[g])
    );
  end

endmodule
